// File: rtl/filter_package.sv
// Shared types and sizing for the receive filter control slice.
package filter_package;

    localparam int RX_SETTING_WIDTH = 3;
    localparam int NUM_RX_SETTINGS  = 5;
    localparam int NUM_UI           = 4;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        RUN    = 2'd1,
        PEND   = 2'd2,
        SETTLE = 2'd3
    } state_t;

    function automatic logic setting_in_range(input logic [RX_SETTING_WIDTH-1:0] setting);
        return int'(setting) < NUM_RX_SETTINGS;
    endfunction

endpackage

// File: rtl/filter_ui_cnt.sv
// UI-event counter: loadable, counts up saturating at MAX or down saturating at zero.
module filter_ui_cnt #(
    parameter int WIDTH = 3,
    parameter int MAX   = 4
) (
    input  logic             clk_sys,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] loadVal_i,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [WIDTH-1:0] count_o
);

    localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = loadVal_i;
        end else if (inc_i && (count_q != MaxVal)) begin
            count_d = count_q + 1'b1;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/filter_ctrl.sv
// Filter control: fills history taps after reset, then sequences receive-setting
// changes so that samples taken around a change are flagged as unusable.
module filter_ctrl
    import filter_package::*;
#(
    parameter int NUM_TAPS        = NUM_UI,
    parameter int PWL_LATENCY     = 1,
    parameter int SETTLE_UI       = 2,
    parameter int DEFAULT_SETTING = 0
) (
    input  logic                        clk_sys,
    input  logic                        rst_n,
    input  logic                        time_eq_in,
    input  logic                        req_valid,
    input  logic [RX_SETTING_WIDTH-1:0] req_setting,
    output logic                        req_ready,
    output logic [RX_SETTING_WIDTH-1:0] rx_setting,
    output logic                        out_valid,
    output logic                        warm,
    output logic                        err_range,
    output logic [1:0]                  state
);

    localparam int FillW   = $clog2(NUM_TAPS + 1);
    localparam int SettleW = (SETTLE_UI > 0) ? $clog2(SETTLE_UI + 1) : 1;
    localparam logic [FillW-1:0] TapsVal    = FillW'(NUM_TAPS);
    localparam logic [FillW-1:0] TapsValM1  = FillW'(NUM_TAPS - 1);
    localparam logic [SettleW-1:0] SettleVal = SettleW'(SETTLE_UI);

    state_t                        state_q, state_d;
    logic [RX_SETTING_WIDTH-1:0]   rxSetting_q, rxSetting_d;
    logic [RX_SETTING_WIDTH-1:0]   pendSetting_q, pendSetting_d;
    logic                          errRange_q, errRange_d;
    logic                          warm_q, warm_d;
    logic [PWL_LATENCY-1:0]        delayLine_q, delayLine_d;

    logic [FillW-1:0]   fillCnt;
    logic [SettleW-1:0] settleCnt;
    logic               settleLoad;
    logic               settleDec;
    logic               reqAccept;
    logic               strobeValid;

    filter_ui_cnt #(.WIDTH(FillW), .MAX(NUM_TAPS)) u_fill_cnt (
        .clk_sys   (clk_sys),
        .rst_n     (rst_n),
        .load_i    (1'b0),
        .loadVal_i ('0),
        .inc_i     (time_eq_in),
        .dec_i     (1'b0),
        .count_o   (fillCnt)
    );

    filter_ui_cnt #(.WIDTH(SettleW), .MAX(SETTLE_UI)) u_settle_cnt (
        .clk_sys   (clk_sys),
        .rst_n     (rst_n),
        .load_i    (settleLoad),
        .loadVal_i (SettleVal),
        .inc_i     (1'b0),
        .dec_i     (settleDec),
        .count_o   (settleCnt)
    );

    // PEND only exists while a request is held, so the state alone gates acceptance.
    assign req_ready   = rst_n && ((state_q == FILL) || (state_q == RUN));
    assign reqAccept   = req_valid && req_ready;
    assign strobeValid = time_eq_in && (state_q == RUN);

    always_comb begin
        state_d       = state_q;
        rxSetting_d   = rxSetting_q;
        pendSetting_d = pendSetting_q;
        errRange_d    = errRange_q;
        settleLoad    = 1'b0;
        settleDec     = 1'b0;
        // warm tracks the counter value it will hold after this edge
        warm_d        = (fillCnt == TapsVal) || (time_eq_in && (fillCnt == TapsValM1));

        delayLine_d    = '0;
        delayLine_d[0] = strobeValid;
        for (int i = 1; i < PWL_LATENCY; i++) begin
            delayLine_d[i] = delayLine_q[i-1];
        end

        unique case (state_q)
            FILL, RUN: begin
                if ((state_q == FILL) && warm_q) begin
                    state_d = RUN;
                end
                if (reqAccept) begin
                    if (!setting_in_range(req_setting)) begin
                        errRange_d = 1'b1;
                        state_d    = state_q;
                    end else if (req_setting != rxSetting_q) begin
                        pendSetting_d = req_setting;
                        state_d       = PEND;
                    end
                end
            end
            PEND: begin
                if (time_eq_in) begin
                    rxSetting_d = pendSetting_q;
                    settleLoad  = 1'b1;
                    if (SETTLE_UI == 0) begin
                        state_d = warm_q ? RUN : FILL;
                    end else begin
                        state_d = SETTLE;
                    end
                end
            end
            SETTLE: begin
                if (settleCnt == '0) begin
                    state_d = warm_q ? RUN : FILL;
                end else if (time_eq_in) begin
                    settleDec = 1'b1;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            state_q       <= FILL;
            rxSetting_q   <= RX_SETTING_WIDTH'(DEFAULT_SETTING);
            pendSetting_q <= '0;
            errRange_q    <= 1'b0;
            warm_q        <= 1'b0;
            delayLine_q   <= '0;
        end else begin
            state_q       <= state_d;
            rxSetting_q   <= rxSetting_d;
            pendSetting_q <= pendSetting_d;
            errRange_q    <= errRange_d;
            warm_q        <= warm_d;
            delayLine_q   <= delayLine_d;
        end
    end

    assign rx_setting = rxSetting_q;
    assign out_valid  = delayLine_q[PWL_LATENCY-1];
    assign warm       = warm_q;
    assign err_range  = errRange_q;
    assign state      = state_q;

endmodule

// File: tb/tb_filter_ctrl.sv
// Directed bench for filter_ctrl with NUM_TAPS=4, PWL_LATENCY=1, SETTLE_UI=2.
module tb_filter_ctrl;
    import filter_package::*;

    logic                        clk_sys;
    logic                        rst_n;
    logic                        time_eq_in;
    logic                        req_valid;
    logic [RX_SETTING_WIDTH-1:0] req_setting;
    logic                        req_ready;
    logic [RX_SETTING_WIDTH-1:0] rx_setting;
    logic                        out_valid;
    logic                        warm;
    logic                        err_range;
    logic [1:0]                  state;

    int errors = 0;
    int checks = 0;

    filter_ctrl #(
        .NUM_TAPS        (4),
        .PWL_LATENCY     (1),
        .SETTLE_UI       (2),
        .DEFAULT_SETTING (0)
    ) dut (
        .clk_sys     (clk_sys),
        .rst_n       (rst_n),
        .time_eq_in  (time_eq_in),
        .req_valid   (req_valid),
        .req_setting (req_setting),
        .req_ready   (req_ready),
        .rx_setting  (rx_setting),
        .out_valid   (out_valid),
        .warm        (warm),
        .err_range   (err_range),
        .state       (state)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic strobe();
        time_eq_in = 1'b1;
        tick();
        time_eq_in = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if (state !== 2'd0) begin errors++; $display("[TB] FAIL reset_state: got %0d expected 0", state); end
        checks++;
        if (rx_setting !== 3'd0) begin errors++; $display("[TB] FAIL reset_rx: got %0d expected 0", rx_setting); end
        checks++;
        if ({warm, err_range, out_valid} !== 3'b000) begin errors++; $display("[TB] FAIL reset_flags: got %b expected 000", {warm, err_range, out_valid}); end
        checks++;
        if (req_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 0", req_ready); end
        rst_n = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL release_ready: got %b expected 1", req_ready); end
    endtask

    task automatic test_fill();
        for (int k = 1; k <= 6; k++) begin
            strobe();
            checks++;
            if (warm !== (k >= 4)) begin errors++; $display("[TB] FAIL fill_warm strobe %0d: got %b expected %b", k, warm, (k >= 4)); end
            checks++;
            if (out_valid !== (k >= 5)) begin errors++; $display("[TB] FAIL fill_ov strobe %0d: got %b expected %b", k, out_valid, (k >= 5)); end
            tick();
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL fill_ov_pulse strobe %0d: got %b expected 0", k, out_valid); end
            tick();
        end
        checks++;
        if (state !== 2'd1) begin errors++; $display("[TB] FAIL fill_run: got %0d expected 1", state); end
    endtask

    task automatic test_setting_change();
        req_valid   = 1'b1;
        req_setting = 3'd2;
        tick();
        req_valid = 1'b0;
        checks++;
        if (state !== 2'd2 || req_ready !== 1'b0) begin errors++; $display("[TB] FAIL chg_pend: got state %0d ready %b expected 2/0", state, req_ready); end
        tick();
        checks++;
        if (rx_setting !== 3'd0) begin errors++; $display("[TB] FAIL chg_rx_before: got %0d expected 0", rx_setting); end
        for (int k = 1; k <= 4; k++) begin
            strobe();
            checks++;
            if (out_valid !== (k == 4)) begin errors++; $display("[TB] FAIL chg_ov strobe %0d: got %b expected %b", k, out_valid, (k == 4)); end
            if (k == 1) begin
                checks++;
                if (rx_setting !== 3'd2 || state !== 2'd3) begin errors++; $display("[TB] FAIL chg_apply: got rx %0d state %0d expected 2/3", rx_setting, state); end
            end
            tick();
            tick();
        end
        checks++;
        if (state !== 2'd1) begin errors++; $display("[TB] FAIL chg_back_run: got %0d expected 1", state); end
    endtask

    task automatic test_range();
        req_valid   = 1'b1;
        req_setting = 3'(NUM_RX_SETTINGS);
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        checks++;
        if (err_range !== 1'b1) begin errors++; $display("[TB] FAIL range_err: got %b expected 1", err_range); end
        checks++;
        if (rx_setting !== 3'd2 || state !== 2'd1) begin errors++; $display("[TB] FAIL range_hold: got rx %0d state %0d expected 2/1", rx_setting, state); end
    endtask

    task automatic test_back_to_back();
        time_eq_in = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ov %0d: got %b expected 1", k, out_valid); end
        end
        time_eq_in = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_tail: got %b expected 0", out_valid); end
    endtask

    task automatic test_same_setting();
        req_valid   = 1'b1;
        req_setting = 3'd2;
        for (int k = 1; k <= 3; k++) begin
            strobe();
            checks++;
            if (out_valid !== 1'b1 || req_ready !== 1'b1 || state !== 2'd1) begin
                errors++;
                $display("[TB] FAIL same_%0d: got ov %b ready %b state %0d expected 1/1/1", k, out_valid, req_ready, state);
            end
            tick();
        end
        req_valid = 1'b0;
        checks++;
        if (err_range !== 1'b1) begin errors++; $display("[TB] FAIL err_sticky: got %b expected 1", err_range); end
    endtask

    task automatic test_same_cycle();
        req_valid   = 1'b1;
        req_setting = 3'd1;
        strobe();
        req_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || state !== 2'd2 || rx_setting !== 3'd2) begin
            errors++;
            $display("[TB] FAIL samecyc_accept: got ov %b state %0d rx %0d expected 1/2/2", out_valid, state, rx_setting);
        end
        tick();
        tick();
        strobe();
        checks++;
        if (out_valid !== 1'b0 || state !== 2'd3 || rx_setting !== 3'd1) begin
            errors++;
            $display("[TB] FAIL samecyc_apply: got ov %b state %0d rx %0d expected 0/3/1", out_valid, state, rx_setting);
        end
        tick();
        tick();
        strobe();
        tick();
        tick();
        strobe();
        tick();
        checks++;
        if (state !== 2'd1) begin errors++; $display("[TB] FAIL samecyc_run: got %0d expected 1", state); end
    endtask

    task automatic test_reset_pend();
        req_valid   = 1'b1;
        req_setting = 3'd3;
        tick();
        req_valid = 1'b0;
        checks++;
        if (state !== 2'd2) begin errors++; $display("[TB] FAIL rstpend_pend: got %0d expected 2", state); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        checks++;
        if (state !== 2'd0 || rx_setting !== 3'd0 || req_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rstpend_release: got state %0d rx %0d ready %b expected 0/0/1", state, rx_setting, req_ready);
        end
        checks++;
        if ({warm, err_range} !== 2'b00) begin errors++; $display("[TB] FAIL rstpend_flags: got %b expected 00", {warm, err_range}); end
        strobe();
        checks++;
        if (rx_setting !== 3'd0 || state !== 2'd0) begin errors++; $display("[TB] FAIL rstpend_discard: got rx %0d state %0d expected 0/0", rx_setting, state); end
    endtask

    initial begin
        rst_n       = 1'b0;
        time_eq_in  = 1'b0;
        req_valid   = 1'b0;
        req_setting = '0;
        test_reset();
        test_fill();
        test_setting_change();
        test_range();
        test_back_to_back();
        test_same_setting();
        test_same_cycle();
        test_reset_pend();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/filter_ctrl.md
FILTER_CTRL -- requirements
Module: filter_ctrl

Interface
REQ-001 SHALL have parameter NUM_TAPS, default NUM_UI, the number of filter history taps to fill after reset.
REQ-002 SHALL have parameter PWL_LATENCY, default 1, the number of clk_sys cycles from a time_eq_in strobe to a valid filter output.
REQ-003 SHALL have parameter SETTLE_UI, default 2, the number of UI events suppressed after a setting change.
REQ-004 SHALL have parameter DEFAULT_SETTING, default 0, the rx_setting value applied at reset.
REQ-005 SHALL have port clk_sys, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-007 SHALL have port time_eq_in, input, 1 bit: UI event strobe, the same signal that drives the filter.
REQ-008 SHALL have port req_valid, input, 1 bit: a setting-change request is offered.
REQ-009 SHALL have port req_setting, input, RX_SETTING_WIDTH bits: the requested setting.
REQ-010 SHALL have port req_ready, output, 1 bit: the request is accepted in a cycle where req_valid and req_ready are both high.
REQ-011 SHALL have port rx_setting, output, RX_SETTING_WIDTH bits: registered setting driven to the filter.
REQ-012 SHALL have port out_valid, output, 1 bit: the filter output is a usable sample in this cycle.
REQ-013 SHALL have port warm, output, 1 bit: all history taps have been filled since reset.
REQ-014 SHALL have port err_range, output, 1 bit: sticky flag set by an out-of-range request.
REQ-015 SHALL have port state, output, 2 bits: current FSM state, for debug.

Function
REQ-016 SHALL implement the FSM states FILL=0, RUN=1, PEND=2 and SETTLE=3.
REQ-017 SHALL keep fill_cnt, a saturating count of time_eq_in strobes that saturates at NUM_TAPS; warm = (fill_cnt == NUM_TAPS), registered.
REQ-018 SHALL transition FILL->RUN in the cycle after fill_cnt reaches NUM_TAPS.
REQ-019 SHALL drive req_ready high only in FILL or RUN with no pending request held.
REQ-020 SHALL handle an accepted request with req_setting >= NUM_RX_SETTINGS by setting err_range, leaving rx_setting unchanged and leaving the state unchanged.
REQ-021 SHALL handle an accepted request with req_setting == rx_setting as a no-op: no state change, no output suppression.
REQ-022 SHALL handle any other accepted request by storing it in pend_setting and entering PEND in the next cycle.
REQ-023 SHALL, in PEND, on the first time_eq_in strobe: load rx_setting <= pend_setting (visible next cycle), load settle_cnt <= SETTLE_UI and enter SETTLE.
REQ-024 SHALL, in SETTLE, decrement settle_cnt on each time_eq_in strobe; when settle_cnt == 0, go to RUN if warm, otherwise go to FILL.
REQ-025 SHALL enter RUN directly from PEND when SETTLE_UI == 0 and warm is high.
REQ-026 SHALL tag a strobe as valid only if it is sampled while state == RUN; the strobe that applies a new setting (PEND) is invalid.
REQ-027 SHALL assert out_valid exactly PWL_LATENCY cycles after a valid strobe, using a shift-register delay line, for one cycle per strobe.
REQ-028 SHALL handle a time_eq_in strobe and an accepted request in the same RUN cycle as follows: the strobe is valid, and the new setting is applied at the next strobe.
REQ-029 SHALL count every strobe in fill_cnt regardless of state.
REQ-030 SHALL handle back-to-back strobes (every cycle) correctly; the delay line holds PWL_LATENCY independent bits.

Reset
REQ-031 SHALL, while rst_n=0 at a clock edge, set: state=FILL, fill_cnt=0, settle_cnt=0, rx_setting=DEFAULT_SETTING, pend_setting=0, delay line cleared, out_valid=0, warm=0, err_range=0 and req_ready=0.
REQ-032 SHALL drive req_ready=1 in the first cycle after reset release.
REQ-033 SHALL discard a pending request when reset is applied mid-operation; no partial setting change occurs.

Structure
REQ-034 SHALL declare the FSM state typedef, and reuse RX_SETTING_WIDTH, NUM_RX_SETTINGS and NUM_UI, from filter_package.
REQ-035 SHALL place the saturating/decrementing UI-event counter in one sub-module, filter_ui_cnt, instantiated for fill_cnt and settle_cnt.
REQ-036 SHALL keep the implementation within 120-400 lines of RTL; all outputs registered except req_ready.

Verification
REQ-037 SHALL run a bench scenario (NUM_TAPS=4, PWL_LATENCY=1): reset then 6 strobes spaced 3 cycles apart -> warm rises after the 4th strobe, and out_valid is first high 1 cycle after the 5th strobe.
REQ-038 SHALL run a bench scenario: in RUN, a request for setting 2 followed by 4 strobes -> rx_setting=2 the cycle after strobe 1, no out_valid for strobes 1-3, out_valid 1 cycle after strobe 4.
REQ-039 SHALL run a bench scenario: a request with req_setting=NUM_RX_SETTINGS -> err_range=1 held, rx_setting unchanged, state stays RUN.
REQ-040 SHALL run a bench scenario: a request equal to the current setting -> req_ready stays high and out_valid continues uninterrupted.
REQ-041 SHALL run a bench scenario: a request and a strobe in the same cycle -> out_valid for that strobe, and the setting applied at the following strobe.
REQ-042 SHALL run a bench scenario: rst_n=0 for 1 cycle while in PEND -> state=FILL, rx_setting=DEFAULT_SETTING and req_ready=1 the cycle after release.
